// File: rtl/demux_16_8_reg.sv
// demux_16_8_reg: register-bank write port. A single 16-bit word is routed to
// one of eight registered outputs via a valid/ready handshake. A clear
// sequencer walks the bank back to RESET_VAL, one entry per clock.
module demux_16_8_reg #(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [WIDTH-1:0]     RESET_VAL = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       selectInput,
  input  logic             clear_req,
  output logic             busy,
  output logic [7:0]       wr_strobe,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       clr_cnt_q;
  logic [7:0]       wr_strobe_q;
  logic [WIDTH-1:0] bank_q [8];

  // A clear request blocks the handshake in the same cycle so it wins over a write.
  assign in_ready  = (state_q == IDLE) && !clear_req;
  assign busy      = (state_q == CLEAR);
  assign wr_strobe = wr_strobe_q;

  assign out0 = bank_q[0];
  assign out1 = bank_q[1];
  assign out2 = bank_q[2];
  assign out3 = bank_q[3];
  assign out4 = bank_q[4];
  assign out5 = bank_q[5];
  assign out6 = bank_q[6];
  assign out7 = bank_q[7];

  // Sequencer and bank: handshake writes in IDLE, one-entry-per-edge sweep in CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_cnt_q   <= 3'd0;
      wr_strobe_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= RESET_VAL;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            // Entering the sweep touches no bank entry at this edge.
            state_q     <= CLEAR;
            clr_cnt_q   <= 3'd0;
            wr_strobe_q <= 8'h00;
          end else if (in_valid) begin
            bank_q[selectInput] <= data_in;
            wr_strobe_q         <= 8'b0000_0001 << selectInput;
          end else begin
            wr_strobe_q <= 8'h00;
          end
        end
        CLEAR: begin
          bank_q[clr_cnt_q] <= RESET_VAL;
          wr_strobe_q       <= 8'b0000_0001 << clr_cnt_q;
          // The 3-bit counter wraps back to 0 on the final entry.
          clr_cnt_q         <= clr_cnt_q + 3'd1;
          if (clr_cnt_q == 3'd7) begin
            state_q <= IDLE;
          end else begin
            state_q <= CLEAR;
          end
        end
        default: begin
          state_q     <= IDLE;
          clr_cnt_q   <= 3'd0;
          wr_strobe_q <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_16_8_reg.sv
// Directed, table-driven bench for demux_16_8_reg plus a reset-during-sweep sequence.
module tb_demux_16_8_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [2:0]  selectInput;
  logic        clear_req;
  logic        busy;
  logic [7:0]  wr_strobe;
  logic [15:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [15:0] outs [8];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld;
    logic [2:0]  sel;
    logic [15:0] data;
    logic        clr;
    logic        exp_ready;   // in_ready seen with these inputs, before the edge
    logic [2:0]  chk_idx;     // which output to inspect after the edge
    logic [15:0] chk_val;
    logic [7:0]  exp_strobe;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[$];

  demux_16_8_reg dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .selectInput(selectInput),
    .clear_req  (clear_req),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4),
    .out5       (out5),
    .out6       (out6),
    .out7       (out7)
  );

  assign outs[0] = out0;
  assign outs[1] = out1;
  assign outs[2] = out2;
  assign outs[3] = out3;
  assign outs[4] = out4;
  assign outs[5] = out5;
  assign outs[6] = out6;
  assign outs[7] = out7;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [2:0] sel, input logic [15:0] data,
                              input logic clr, input logic rdy, input logic [2:0] idx,
                              input logic [15:0] val, input logic [7:0] stb, input logic bsy);
    vec_t v;
    v.vld = vld; v.sel = sel; v.data = data; v.clr = clr; v.exp_ready = rdy;
    v.chk_idx = idx; v.chk_val = val; v.exp_strobe = stb; v.exp_busy = bsy;
    return v;
  endfunction

  task automatic drive(input logic vld, input logic [2:0] sel, input logic [15:0] data,
                       input logic clr);
    in_valid = vld; selectInput = sel; data_in = data; clear_req = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] one8;
    one8 = 8'h01;

    // Single write, then an idle cycle.
    vecs.push_back(mk(1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1, 3'd5, 16'hBEEF, 8'h20, 1'b0));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'hBEEF, 8'h00, 1'b0));
    // Back-to-back writes to every index.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 3'(i), 16'h1000 + 16'(i), 1'b0, 1'b1, 3'(i),
                        16'h1000 + 16'(i), one8 << i, 1'b0));
    // Clear request: no bank change at this edge.
    vecs.push_back(mk(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h1000, 8'h00, 1'b1));
    // Sweep with a write held on sel 3 that must not be taken.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 3'd3, 16'hFFFF, 1'b0, 1'b0, 3'(i), 16'h0000, one8 << i, i < 7));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h0000, 8'h00, 1'b0));
    // Load out2, then valid and clear together: the clear wins.
    vecs.push_back(mk(1'b1, 3'd2, 16'h5555, 1'b0, 1'b1, 3'd2, 16'h5555, 8'h04, 1'b0));
    vecs.push_back(mk(1'b1, 3'd2, 16'h1234, 1'b1, 1'b0, 3'd2, 16'h5555, 8'h00, 1'b1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'(i), 16'h0000, one8 << i, i < 7));
    vecs.push_back(mk(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h0000, 8'h00, 1'b0));

    // Reset state.
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("reset_out%0d", i), outs[i], 16'h0000);
    check("reset_strobe", {8'h00, wr_strobe}, 16'h0000);
    check("reset_ready", {15'd0, in_ready}, 16'h0001);
    check("reset_busy", {15'd0, busy}, 16'h0000);
    tick();
    tick();
    reset = 1'b0;

    // Table-driven vectors.
    for (int n = 0; n < vecs.size(); n++) begin
      drive(vecs[n].vld, vecs[n].sel, vecs[n].data, vecs[n].clr);
      #1;
      check($sformatf("v%0d_ready", n), {15'd0, in_ready}, {15'd0, vecs[n].exp_ready});
      tick();
      check($sformatf("v%0d_out%0d", n, vecs[n].chk_idx), outs[vecs[n].chk_idx], vecs[n].chk_val);
      check($sformatf("v%0d_strobe", n), {8'h00, wr_strobe}, {8'h00, vecs[n].exp_strobe});
      check($sformatf("v%0d_busy", n), {15'd0, busy}, {15'd0, vecs[n].exp_busy});
    end

    // Reset asserted in the middle of a sweep.
    drive(1'b1, 3'd1, 16'hAAAA, 1'b0); tick();
    drive(1'b1, 3'd6, 16'h6666, 1'b0); tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b1); tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    tick(); tick(); tick();
    check("mid_busy", {15'd0, busy}, 16'h0001);
    check("mid_out1", out1, 16'h0000);
    check("mid_out6", out6, 16'h6666);
    check("mid_strobe", {8'h00, wr_strobe}, 16'h0004);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("rst_mid_out%0d", i), outs[i], 16'h0000);
    check("rst_mid_busy", {15'd0, busy}, 16'h0000);
    check("rst_mid_strobe", {8'h00, wr_strobe}, 16'h0000);
    #1;
    reset = 1'b0;
    drive(1'b1, 3'd7, 16'hABCD, 1'b0);
    #1;
    check("post_ready", {15'd0, in_ready}, 16'h0001);
    tick();
    check("post_out7", out7, 16'hABCD);
    check("post_out6", out6, 16'h0000);
    check("post_strobe", {8'h00, wr_strobe}, 16'h0080);
    check("post_busy", {15'd0, busy}, 16'h0000);
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    check("post_idle_strobe", {8'h00, wr_strobe}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
